// File: rtl/mcp3008_responder.sv
// mcp3008_responder
//   Emulates an MCP3008-class 8-channel ADC on a bit-banged SPI link.
//   Every pin is oversampled in the clk domain. The conversion result is
//   taken from a parallel per-channel bus when the D0 command bit arrives.
//
// Ports
//   clk, rst_n   : system clock, asynchronous active-low reset
//   ad_clk       : SPI clock from the initiator (idles low)
//   cs           : chip select, active low
//   din          : command bits from the initiator
//   dout         : response bit
//   dout_oe      : high while dout is driven (used by the top-level tristate)
//   ch_data      : 8 channels, channel n at [n*RES +: RES]
//   busy         : high from the start bit until the frame ends (cs rises)
//   frame_done   : one-clk pulse one clk after B0 has been driven
//   last_cmd     : {SGL,D2,D1,D0} of the most recent accepted command
//
// Optional feature
//   MCP3008_RESPONDER_LSB_TAIL_EN : after B0, repeat B1..B(RES-1) LSB first,
//   then 0s. Without it the tail is all 0s.
module mcp3008_responder #(
  parameter int RES         = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ad_clk,
  input  logic             cs,
  input  logic             din,
  output logic             dout,
  output logic             dout_oe,
  input  logic [8*RES-1:0] ch_data,
  output logic             busy,
  output logic             frame_done,
  output logic [3:0]       last_cmd
);

  localparam int CW = $clog2(RES);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_CMD, S_NULL, S_DATA, S_TAIL
  } state_t;

  logic [SYNC_STAGES-1:0] ack_sync_q, cs_sync_q, din_sync_q;
  logic                   ack_prev_q;
  state_t                 state_q;
  logic [2:0]             cmd_q;
  logic [CW-1:0]          cnt_q;
  logic [RES-1:0]         sr_q;
  logic                   dout_q, oe_q, busy_q, done_q, pend_q;
  logic [3:0]             last_cmd_q;

  logic ack_s, cs_s, din_s, rise, fall;
  assign ack_s = ack_sync_q[SYNC_STAGES-1];
  assign cs_s  = cs_sync_q[SYNC_STAGES-1];
  assign din_s = din_sync_q[SYNC_STAGES-1];
  assign rise  = ack_s & ~ack_prev_q;
  assign fall  = ~ack_s & ack_prev_q;

  // Result for the command completed by the bit now on din_s.
  logic [3:0]     cmd_full;
  logic [RES-1:0] ch_sel, ch_p, ch_n, res_calc;
  assign cmd_full = {cmd_q, din_s};
  assign ch_sel   = ch_data[int'(cmd_full[2:0])       * RES +: RES];
  assign ch_p     = ch_data[int'({cmd_full[2:1], 1'b0}) * RES +: RES];
  assign ch_n     = ch_data[int'({cmd_full[2:1], 1'b1}) * RES +: RES];

  always_comb begin
    res_calc = '0;
    if (cmd_full[3])                 res_calc = ch_sel;
    else if (!cmd_full[0] && ch_p >= ch_n) res_calc = ch_p - ch_n;
    else if ( cmd_full[0] && ch_n >= ch_p) res_calc = ch_n - ch_p;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync_q <= '0;
      cs_sync_q  <= '1;
      din_sync_q <= '0;
      ack_prev_q <= 1'b0;
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      cnt_q      <= '0;
      sr_q       <= '0;
      dout_q     <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pend_q     <= 1'b0;
      last_cmd_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ad_clk};
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], din};
      ack_prev_q <= ack_s;
      // frame_done lags the B0 drive by one clk
      done_q     <= pend_q;
      pend_q     <= 1'b0;
      if (cs_s) begin
        state_q <= S_IDLE;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
        dout_q  <= 1'b0;
        pend_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: state_q <= S_WAIT;
          S_WAIT: if (rise && din_s) begin
            state_q <= S_CMD;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
          S_CMD: if (rise) begin
            if (cnt_q == CW'(3)) begin
              sr_q       <= res_calc;
              last_cmd_q <= cmd_full;
              state_q    <= S_NULL;
            end else begin
              cmd_q <= {cmd_q[1:0], din_s};
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_NULL: if (fall) begin
            oe_q    <= 1'b1;
            dout_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_DATA;
          end
          S_DATA: if (fall) begin
            // Rotate so the register holds the original result after B0.
            dout_q <= sr_q[RES-1];
            sr_q   <= {sr_q[RES-2:0], sr_q[RES-1]};
            if (cnt_q == CW'(RES-1)) begin
              pend_q  <= 1'b1;
              state_q <= S_TAIL;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_TAIL: if (fall) begin
`ifdef MCP3008_RESPONDER_LSB_TAIL_EN
            // Shifting right with zero fill yields B1..B(RES-1), then 0s.
            dout_q <= sr_q[1];
            sr_q   <= {1'b0, sr_q[RES-1:1]};
`else
            dout_q <= 1'b0;
`endif
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign dout       = dout_q;
  assign dout_oe    = oe_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign last_cmd   = last_cmd_q;

endmodule

// File: tb/tb_mcp3008_responder.sv
module tb_mcp3008_responder;
  localparam int RES = 10;
  localparam int SS  = 2;
  localparam int H   = 6;   // SPI half period in clk

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             ad_clk = 1'b0, cs = 1'b1, din = 1'b0;
  logic             dout, dout_oe, busy, frame_done;
  logic [3:0]       last_cmd;
  logic [8*RES-1:0] ch_data = '0;

  mcp3008_responder #(.RES(RES), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .ad_clk(ad_clk), .cs(cs), .din(din),
    .dout(dout), .dout_oe(dout_oe), .ch_data(ch_data), .busy(busy),
    .frame_done(frame_done), .last_cmd(last_cmd)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, done_cnt = 0;
  int exp_q[$];

  always @(posedge clk) if (frame_done) done_cnt++;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int chv(input int n);
    return int'(ch_data[n*RES +: RES]);
  endfunction

  function automatic int model(input logic [3:0] c);
    int a, b, d;
    if (c[3]) return chv(int'(c[2:0]));
    a = chv(int'(c[2:1]) * 2);
    b = chv(int'(c[2:1]) * 2 + 1);
    d = c[0] ? b - a : a - b;
    return (d < 0) ? 0 : d;
  endfunction

  task automatic set_ch(input int n, input int v);
    ch_data[n*RES +: RES] = v[RES-1:0];
  endtask

  // One SPI bit: sample dout just before the rising edge.
  task automatic spi_cyc(input logic b, output logic got);
    din = b;
    wclk(H);
    got = dout;
    ad_clk = 1'b1;
    wclk(H);
    ad_clk = 1'b0;
  endtask

  // mode 0: full frame, 1: cs abort after 4 data bits, 2: reset mid-DATA
  task automatic frame(input string tag, input logic [3:0] c, input int nz,
                       input int ntail, input int mode, input bit mutate);
    int r, nd, d0, e;
    logic g;
    r  = model(c);
    nd = (mode == 0) ? RES : 4;
    d0 = done_cnt;
    cs = 1'b0;
    wclk(H);
    for (int i = 0; i < nz; i++) spi_cyc(1'b0, g);
    spi_cyc(1'b1, g);
    for (int i = 3; i >= 0; i--) spi_cyc(c[i], g);
    exp_q.push_back(0);
    for (int i = RES - 1; i >= RES - nd; i--) exp_q.push_back(r[i]);
    for (int k = 0; k < ntail; k++)
`ifdef MCP3008_RESPONDER_LSB_TAIL_EN
      exp_q.push_back((k + 1 < RES) ? int'(r[k+1]) : 0);
`else
      exp_q.push_back(0);
`endif
    if (mutate) ch_data = ~ch_data;
    check({tag, " busy"}, busy, 1);
    for (int i = 0; i < 1 + nd + ntail; i++) begin
      spi_cyc(1'b0, g);
      e = exp_q.pop_front();
      check($sformatf("%s bit%0d", tag, i), g, e);
      if (i == 0) check({tag, " oe"}, dout_oe, 1);
    end
    if (mode == 2) begin
      #2 rst_n = 1'b0;
      #1;
      check({tag, " rst dout"}, dout, 0);
      check({tag, " rst oe"}, dout_oe, 0);
      check({tag, " rst busy"}, busy, 0);
      check({tag, " rst last_cmd"}, last_cmd, 0);
      cs = 1'b1;
      wclk(3);
      rst_n = 1'b1;
      wclk(4);
      check({tag, " done"}, done_cnt - d0, 0);
    end else begin
      cs = 1'b1;
      wclk(SS + 2);
      check({tag, " oe off"}, dout_oe, 0);
      check({tag, " busy off"}, busy, 0);
      wclk(H);
      check({tag, " done"}, done_cnt - d0, (mode == 0) ? 1 : 0);
      check({tag, " last_cmd"}, last_cmd, c);
    end
  endtask

  initial begin
    wclk(3);
    check("reset dout", dout, 0);
    check("reset oe", dout_oe, 0);
    check("reset busy", busy, 0);
    check("reset done", frame_done, 0);
    check("reset last_cmd", last_cmd, 0);
    rst_n = 1'b1;
    wclk(5);

    set_ch(3, 'h2A5);
    frame("sgl3", 4'b1011, 0, 0, 0, 1'b1);

    ch_data = '0; set_ch(0, 100); set_ch(1, 300);
    frame("diff01", 4'b0001, 0, 0, 0, 1'b0);
    frame("diff10", 4'b0000, 0, 0, 0, 1'b0);

    set_ch(7, 'h3FF);
    frame("zeros7", 4'b1111, 3, 0, 0, 1'b0);

    set_ch(2, 'h1C3);
    frame("abort", 4'b1010, 0, 0, 1, 1'b0);
    frame("after_abort", 4'b1010, 0, 0, 0, 1'b0);

    frame("rstmid", 4'b1010, 0, 0, 2, 1'b0);
    exp_q.delete();
    frame("after_rst", 4'b1011, 0, 0, 0, 1'b0);

    set_ch(5, 'h155);
    frame("tail5", 4'b1101, 0, 12, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
